mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: STARVE_MAX, 4, LSU-over-IFU wins allowed before IFU is forced (1..15).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake; fetch is always a word read.
REQ-007 ifu_addr  in  ADDR_W  fetch address.
REQ-008 ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake.
REQ-009 ifu_rdata  out  DATA_W  fetched word.
REQ-010 lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake.
REQ-011 lsu_wr_en  in  1  1 = store, 0 = load.
REQ-012 lsu_rw_type  in  3  width/sign code, passed through unchanged: bit2 = unsigned; [1:0] 00 byte, 01 half, other word.
REQ-013 lsu_addr / lsu_wdata  in  ADDR_W / DATA_W  access address and store data.
REQ-014 lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake; issued for loads and stores.
REQ-015 lsu_rdata  out  DATA_W  load data; 0 for stores.
REQ-016 mem_req_valid / mem_req_ready  out / in  1  downstream request handshake.
REQ-017 mem_wr_en, mem_rw_type, mem_addr, mem_wdata  out  1/3/ADDR_W/DATA_W  downstream command; held stable while mem_req_valid=1.
REQ-018 mem_rsp_valid / mem_rdata  in  1 / DATA_W  downstream completion, one per accepted request.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, SEND, WAIT, RESP; exactly one transaction is outstanding at a time.
REQ-021 IDLE: if at least one requester is valid, the winner's req_ready SHALL be 1 combinationally; the winner's command, with IFU forced to wr_en=0 and rw_type=010, and the owner ID SHALL be latched; next state is SEND.
REQ-022 Arbitration: LSU wins when both are valid, unless starve_cnt == STARVE_MAX, in which case IFU wins.
REQ-023 starve_cnt: increments, saturating at STARVE_MAX, on each LSU grant while ifu_req_valid=1; clears to 0 on each IFU grant.
REQ-024 In all states other than IDLE, both req_ready outputs SHALL be 0.
REQ-025 SEND: mem_req_valid=1; on mem_req_ready=1, next state is WAIT; the command SHALL NOT change while waiting for mem_req_ready.
REQ-026 WAIT: on mem_rsp_valid=1, mem_rdata SHALL be captured (0 for stores) and next state is RESP.
REQ-027 mem_rsp_valid SHALL be ignored in IDLE, SEND and RESP.
REQ-028 RESP: the owner's rsp_valid=1 with the captured data; on its rsp_ready=1, next state is IDLE; the non-owner rsp_valid SHALL stay 0.
REQ-029 Minimum latency: request accepted at cycle T; mem_req_valid at T+1; with mem_req_ready at T+1 and mem_rsp_valid at T+2, rsp_valid is asserted at T+3.
REQ-030 Back-to-back: a new grant SHALL be possible in the first IDLE cycle after RESP completes.
REQ-031 rdata outputs SHALL hold the last captured value outside RESP.

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, starve_cnt=0, owner=LSU, and all latched command and data registers SHALL be 0.
REQ-033 During rst=1, all valid/ready outputs and busy SHALL be 0.
REQ-034 Reset mid-transaction SHALL abort it: no response is returned, and a late mem_rsp_valid is dropped per REQ-027.

Structure
REQ-035 Package mem_arb_pkg SHALL hold: the state enum, the owner enum (OWN_IFU, OWN_LSU), the rw_type encodings (RW_B, RW_H, RW_W, RW_BU, RW_HU) and the default STARVE_MAX.
REQ-036 A single sub-module, mem_arb_pick, SHALL hold the combinational winner selection and the starve_cnt register; everything else stays in mem_arbiter.

Verification
REQ-037 IFU-only read at 0x100, memory ready immediately and rdata 0x00000013 next cycle -> ifu_rsp_valid at T+3 with ifu_rdata=0x00000013; mem_wr_en=0; mem_rw_type=010.
REQ-038 Both requesters valid continuously, STARVE_MAX=4 -> grant sequence L,L,L,L,I,L,L,L,L,I.
REQ-039 LSU store, byte, addr 0x203, wdata 0xAB; mem_req_ready held low 3 cycles -> mem_addr/mem_wdata/mem_rw_type=000 stable across all 4 SEND cycles; lsu_rsp_valid with lsu_rdata=0.
REQ-040 LSU load with lsu_rsp_ready low 5 cycles -> lsu_rsp_valid and lsu_rdata held; ifu_req_ready=0 throughout; IFU granted in the IDLE cycle after the handshake.
REQ-041 rst pulsed while in WAIT, then mem_rsp_valid=1 arrives -> no rsp_valid on either port; busy=0; next request is served normally.
REQ-042 Spurious mem_rsp_valid in IDLE and in SEND -> no state change; no response is emitted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arb_pkg;

  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  // bit2 = unsigned, [1:0] = size
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between IFU and LSU with an IFU anti-starvation counter.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic gnt_ifu_o,
  output logic gnt_lsu_o
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;
  logic       starved;

  assign starved   = (cnt_q == CNT_MAX);
  assign gnt_lsu_o = en_i && lsu_valid_i && !(ifu_valid_i && starved);
  assign gnt_ifu_o = en_i && ifu_valid_i && !gnt_lsu_o;

  // Only LSU wins that actually held off a waiting IFU count toward starvation.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_ifu_o)
      cnt_d = '0;
    else if (gnt_lsu_o && ifu_valid_i && !starved)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU, LSU) single-outstanding memory arbiter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wr_en,
  input  logic [2:0]        lsu_rw_type,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wr_en,
  output logic [2:0]        mem_rw_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_ifu, gnt_lsu;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk         (clk),
    .rst         (rst),
    .en_i        ((state_q == ST_IDLE) && !rst),
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .gnt_ifu_o   (gnt_ifu),
    .gnt_lsu_o   (gnt_lsu)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wr_en_d       = wr_en_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = gnt_ifu;
        lsu_req_ready = gnt_lsu;
        if (gnt_lsu) begin
          owner_d = OWN_LSU;
          wr_en_d = lsu_wr_en;
          rw_d    = lsu_rw_type;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          state_d = ST_SEND;
        end else if (gnt_ifu) begin
          owner_d = OWN_IFU;
          wr_en_d = 1'b0;
          rw_d    = RW_W;
          addr_d  = ifu_addr;
          wdata_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        mem_req_valid = !rst;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = wr_en_q ? '0 : mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q == OWN_LSU) begin
          lsu_rsp_valid = !rst;
          if (lsu_rsp_ready) state_d = ST_IDLE;
        end else begin
          ifu_rsp_valid = !rst;
          if (ifu_rsp_ready) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_LSU;
      wr_en_q <= 1'b0;
      rw_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_en_q <= wr_en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_rw_type = rw_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign ifu_rdata   = rdata_q;
  assign lsu_rdata   = rdata_q;
  assign busy        = (state_q != ST_IDLE) && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, arbitration, stalls, reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wr_en, lsu_rsp_valid, lsu_rsp_ready;
  logic [2:0]  lsu_rw_type;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wr_en, mem_rsp_valid;
  logic [2:0]  mem_rw_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wr_en(lsu_wr_en),
    .lsu_rw_type(lsu_rw_type), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wr_en(mem_wr_en),
    .mem_rw_type(mem_rw_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Inputs change 1ns after the edge; outputs are sampled 1ns later still.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_wr_en = 0; lsu_rw_type = 0; lsu_addr = 0; lsu_wdata = 0;
    lsu_rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
  endtask

  // Runs one transaction with an instantly ready memory; reports who was granted.
  task automatic serve(input logic [31:0] rd, output logic gi, output logic gl,
                       output logic [31:0] got, output logic gotv);
    #1; gi = ifu_req_ready; gl = lsu_req_ready;
    tick(); mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = rd;
    tick(); mem_rsp_valid = 0; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    #1; gotv = ifu_rsp_valid | lsu_rsp_valid; got = gl ? lsu_rdata : ifu_rdata;
    tick(); ifu_rsp_ready = 0; lsu_rsp_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1;
    ifu_req_valid = 1; lsu_req_valid = 1;
    tick(); tick(); #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, busy} !== 6'b0) begin
      $display("FAIL reset_outputs got=%b exp=000000",
        {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, busy});
      failures++;
    end
    checks++;
    if ({mem_wr_en, mem_rw_type, mem_addr, mem_wdata, ifu_rdata} !== '0) begin
      $display("FAIL reset_regs addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, ifu_rdata);
      failures++;
    end
    idle_inputs(); rst = 0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1; ifu_addr = 32'h100; mem_req_ready = 1;
    #1; checks++;
    if (ifu_req_ready !== 1 || lsu_req_ready !== 0) begin
      $display("FAIL ifu_grant ifu_rdy=%b lsu_rdy=%b exp=1/0", ifu_req_ready, lsu_req_ready);
      failures++;
    end
    tick(); ifu_req_valid = 0; ifu_addr = 32'hFFFF;
    #1; checks++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h100 || mem_wr_en !== 0 || mem_rw_type !== 3'b010 || busy !== 1) begin
      $display("FAIL ifu_send v=%b addr=%h we=%b rw=%b busy=%b exp=1/100/0/010/1",
        mem_req_valid, mem_addr, mem_wr_en, mem_rw_type, busy);
      failures++;
    end
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h13;
    #1; checks++;
    if (ifu_rsp_valid !== 0 || mem_req_valid !== 0) begin
      $display("FAIL ifu_wait rsp_v=%b req_v=%b exp=0/0", ifu_rsp_valid, mem_req_valid);
      failures++;
    end
    tick(); mem_rsp_valid = 0; mem_rdata = 0; ifu_rsp_ready = 1;
    #1; checks++;
    if (ifu_rsp_valid !== 1 || ifu_rdata !== 32'h13 || lsu_rsp_valid !== 0) begin
      $display("FAIL ifu_resp_T3 v=%b data=%h lsu_v=%b exp=1/00000013/0",
        ifu_rsp_valid, ifu_rdata, lsu_rsp_valid);
      failures++;
    end
    tick(); ifu_rsp_ready = 0;
    #1; checks++;
    if (busy !== 0 || ifu_rsp_valid !== 0 || ifu_rdata !== 32'h13) begin
      $display("FAIL ifu_done busy=%b v=%b data=%h exp=0/0/00000013", busy, ifu_rsp_valid, ifu_rdata);
      failures++;
    end
  endtask

  task automatic test_starve();
    logic [7:0] exp_seq [10];
    logic gi, gl, gotv;
    logic [31:0] got;
    exp_seq = '{"L","L","L","L","I","L","L","L","L","I"};
    ifu_req_valid = 1; ifu_addr = 32'h400; lsu_req_valid = 1; lsu_addr = 32'h800;
    for (int i = 0; i < 10; i++) begin
      serve(32'h1000 + i, gi, gl, got, gotv);
      checks++;
      if ((gl ? "L" : (gi ? "I" : "-")) !== exp_seq[i] || (gi & gl)) begin
        $display("FAIL starve_grant%0d got=%s exp=%s", i, (gl ? "L" : (gi ? "I" : "-")), exp_seq[i]);
        failures++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_stall();
    lsu_req_valid = 1; lsu_wr_en = 1; lsu_rw_type = 3'b000; lsu_addr = 32'h203; lsu_wdata = 32'hAB;
    #1; checks++;
    if (lsu_req_ready !== 1) begin
      $display("FAIL store_grant rdy=%b exp=1", lsu_req_ready); failures++;
    end
    tick(); idle_inputs(); lsu_addr = 32'h5555; lsu_wdata = 32'h6666; lsu_rw_type = 3'b111;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #1; checks++;
      if (mem_req_valid !== 1 || mem_addr !== 32'h203 || mem_wdata !== 32'hAB ||
          mem_rw_type !== 3'b000 || mem_wr_en !== 1) begin
        $display("FAIL store_send%0d v=%b addr=%h wd=%h rw=%b we=%b exp=1/203/ab/000/1",
          i, mem_req_valid, mem_addr, mem_wdata, mem_rw_type, mem_wr_en);
        failures++;
      end
      tick();
    end
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
    tick(); mem_rsp_valid = 0; lsu_rsp_ready = 1;
    #1; checks++;
    if (lsu_rsp_valid !== 1 || lsu_rdata !== 32'h0 || ifu_rsp_valid !== 0) begin
      $display("FAIL store_resp v=%b data=%h ifu_v=%b exp=1/00000000/0", lsu_rsp_valid, lsu_rdata, ifu_rsp_valid);
      failures++;
    end
    tick(); idle_inputs();
  endtask

  task automatic test_load_hold();
    logic gi, gl, gotv;
    logic [31:0] got;
    ifu_req_valid = 1; ifu_addr = 32'h900;
    lsu_req_valid = 1; lsu_addr = 32'h300;
    #1; checks++;
    if (lsu_req_ready !== 1 || ifu_req_ready !== 0) begin
      $display("FAIL load_grant lsu=%b ifu=%b exp=1/0", lsu_req_ready, ifu_req_ready); failures++;
    end
    tick(); lsu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h55AA1234;
    tick(); mem_rsp_valid = 0; mem_rdata = 0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (lsu_rsp_valid !== 1 || lsu_rdata !== 32'h55AA1234 || ifu_req_ready !== 0) begin
        $display("FAIL load_hold%0d v=%b data=%h ifu_rdy=%b exp=1/55aa1234/0",
          i, lsu_rsp_valid, lsu_rdata, ifu_req_ready);
        failures++;
      end
      tick();
    end
    lsu_rsp_ready = 1;
    tick(); lsu_rsp_ready = 0;
    #1; checks++;
    if (ifu_req_ready !== 1 || lsu_rsp_valid !== 0) begin
      $display("FAIL load_b2b ifu_rdy=%b lsu_v=%b exp=1/0", ifu_req_ready, lsu_rsp_valid); failures++;
    end
    serve(32'h77, gi, gl, got, gotv);
    checks++;
    if (gi !== 1 || gotv !== 1 || got !== 32'h77) begin
      $display("FAIL load_ifu_follow gi=%b v=%b data=%h exp=1/1/00000077", gi, gotv, got); failures++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic gi, gl, gotv;
    logic [31:0] got;
    ifu_req_valid = 1; ifu_addr = 32'hA00;
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; rst = 1;
    #1; checks++;
    if (busy !== 0 || mem_req_valid !== 0) begin
      $display("FAIL rstmid_during busy=%b req_v=%b exp=0/0", busy, mem_req_valid); failures++;
    end
    tick(); rst = 0; mem_rsp_valid = 1; mem_rdata = 32'hBAD0BAD0; ifu_rsp_ready = 1;
    #1; checks++;
    if (ifu_rsp_valid !== 0 || lsu_rsp_valid !== 0 || busy !== 0) begin
      $display("FAIL rstmid_late ifu_v=%b lsu_v=%b busy=%b exp=0/0/0", ifu_rsp_valid, lsu_rsp_valid, busy);
      failures++;
    end
    tick(); mem_rsp_valid = 0; ifu_rsp_ready = 0;
    #1; checks++;
    if (ifu_rsp_valid !== 0 || busy !== 0 || ifu_rdata !== 32'h0) begin
      $display("FAIL rstmid_after v=%b busy=%b data=%h exp=0/0/00000000", ifu_rsp_valid, busy, ifu_rdata);
      failures++;
    end
    lsu_req_valid = 1; lsu_addr = 32'h40;
    serve(32'hCAFEF00D, gi, gl, got, gotv);
    checks++;
    if (gl !== 1 || gotv !== 1 || got !== 32'hCAFEF00D) begin
      $display("FAIL rstmid_next gl=%b v=%b data=%h exp=1/1/cafef00d", gl, gotv, got); failures++;
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    mem_rsp_valid = 1; mem_rdata = 32'h11111111;
    tick(); mem_rsp_valid = 0;
    #1; checks++;
    if (busy !== 0 || ifu_rsp_valid !== 0 || lsu_rsp_valid !== 0 || lsu_rdata !== 32'hCAFEF00D) begin
      $display("FAIL spur_idle busy=%b iv=%b lv=%b data=%h exp=0/0/0/cafef00d",
        busy, ifu_rsp_valid, lsu_rsp_valid, lsu_rdata);
      failures++;
    end
    lsu_req_valid = 1; lsu_addr = 32'h80;
    tick(); lsu_req_valid = 0; mem_rsp_valid = 1; mem_rdata = 32'h22222222;
    tick(); mem_rsp_valid = 0;
    #1; checks++;
    if (mem_req_valid !== 1 || lsu_rsp_valid !== 0) begin
      $display("FAIL spur_send req_v=%b lsu_v=%b exp=1/0", mem_req_valid, lsu_rsp_valid); failures++;
    end
    mem_req_ready = 1;
    tick(); mem_req_ready = 0;
    #1; checks++;
    if (mem_req_valid !== 0 || lsu_rsp_valid !== 0 || busy !== 1) begin
      $display("FAIL spur_wait req_v=%b lsu_v=%b busy=%b exp=0/0/1", mem_req_valid, lsu_rsp_valid, busy);
      failures++;
    end
    mem_rsp_valid = 1; mem_rdata = 32'h33333333;
    tick(); mem_rsp_valid = 0; lsu_rsp_ready = 1;
    #1; checks++;
    if (lsu_rsp_valid !== 1 || lsu_rdata !== 32'h33333333) begin
      $display("FAIL spur_resp v=%b data=%h exp=1/33333333", lsu_rsp_valid, lsu_rdata); failures++;
    end
    tick(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_starve();
    test_store_stall();
    test_load_hold();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
